// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared RAM sizing defaults and arbiter state encoding
//
// Purpose: constants and types shared by the RAM, the address mux and the
//          RAM arbiter.
// Contents:
//   RAM_AW, RAM_DW - default RAM address / data widths
//   arb_state_t    - arbiter sequencer states (IDLE, ACC, RSP)
package risc_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ACC  = 2'b01,
    ARB_RSP  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - two-way round-robin pick with lock override
//
// Purpose: decides which port, if any, the arbiter grants in IDLE.
// Ports:
//   req0, req1 - in  access requests
//   last       - in  most recently served port
//   lock_own   - in  port 'last' holds the arbiter reserved
//   valid      - out a grant should be made
//   sel        - out port to grant (meaningful when valid=1)
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock_own,
  output logic valid,
  output logic sel
);

  always_comb begin
    valid = 1'b0;
    sel   = 1'b0;
    if (lock_own) begin
      // Only the lock holder may be granted; the other port is ignored
      // even if it is the only one requesting.
      sel   = last;
      valid = last ? req1 : req0;
    end else if (req0 && req1) begin
      // Tie: serve the port that was not served most recently.
      sel   = ~last;
      valid = 1'b1;
    end else if (req0) begin
      sel   = 1'b0;
      valid = 1'b1;
    end else if (req1) begin
      sel   = 1'b1;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter for the single-port data RAM
//
// Purpose: serialises CPU (port 0) and loader (port 1) accesses through an
//          IDLE -> ACC -> RSP sequencer and drives the RAM strobes.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   req*/we*/lock*/addr*/wdata* - per-port request, direction, lock, address, data
//   gnt0, gnt1                - grant, high through ACC and RSP of that port
//   done0, done1              - one-cycle completion pulse in RSP
//   rdata                     - read data, valid with done, held afterwards
//   ram_addr, ram_wdata       - latched address / write data to the RAM
//   ram_rdata                 - combinational RAM read data
//   ram_ena/ram_read/ram_write - RAM strobes, active only in ACC
module ram_arbiter
  import risc_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          ram_ena,
  output logic          ram_read,
  output logic          ram_write
);

  arb_state_t state;
  logic       sel_q;
  logic       we_q;
  logic       last;
  logic       lock_own;
  logic       pick_valid;
  logic       pick_sel;

  rr_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last     (last),
    .lock_own (lock_own),
    .valid    (pick_valid),
    .sel      (pick_sel)
  );

  // Strobes come straight from the state register so an asynchronous reset
  // removes them immediately, mid-access.
  assign ram_ena   = (state == ARB_ACC);
  assign ram_read  = ram_ena & ~we_q;
  assign ram_write = ram_ena &  we_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      last      <= 1'b1;
      lock_own  <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            sel_q     <= pick_sel;
            we_q      <= pick_sel ? we1    : we0;
            ram_addr  <= pick_sel ? addr1  : addr0;
            ram_wdata <= pick_sel ? wdata1 : wdata0;
            gnt0      <= ~pick_sel;
            gnt1      <=  pick_sel;
            state     <= ARB_ACC;
          end
        end
        ARB_ACC: begin
          if (!we_q) begin
            rdata <= ram_rdata;
          end
          done0 <= ~sel_q;
          done1 <=  sel_q;
          state <= ARB_RSP;
        end
        ARB_RSP: begin
          done0    <= 1'b0;
          done1    <= 1'b0;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          last     <= sel_q;
          // Lock is sampled in RSP: the holder keeps the arbiter until it
          // finishes an access with its lock input low.
          lock_own <= sel_q ? lock1 : lock0;
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic       ram_ena, ram_read, ram_write;

  logic [7:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .lock0     (lock0),
    .lock1     (lock1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ena   (ram_ena),
    .ram_read  (ram_read),
    .ram_write (ram_write)
  );

  assign ram_rdata = mem[ram_addr];

  // RAM model: initial contents, then synchronous writes on ram_write.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h5A;
    forever begin
      @(posedge clk);
      if (ram_write) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    #2;
    // Reset state
    chk("rst_gnt",   {gnt1, gnt0}, 2'b00);
    chk("rst_done",  {done1, done0}, 2'b00);
    chk("rst_strb",  {ram_ena, ram_read, ram_write}, 3'b000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_addr",  ram_addr, 8'h00);
    chk("rst_wdata", ram_wdata, 8'h00);
    tick(1);
    rst = 1'b1;
    tick(1);

    // Single read, port 0, address 0x10
    req0 = 1; we0 = 0; addr0 = 8'h10;
    tick(1);
    chk("rd_acc_gnt",  {gnt1, gnt0}, 2'b01);
    chk("rd_acc_strb", {ram_ena, ram_read, ram_write}, 3'b110);
    chk("rd_acc_addr", ram_addr, 8'h10);
    chk("rd_acc_done", done0, 1'b0);
    tick(1);
    chk("rd_rsp_gnt",  {gnt1, gnt0}, 2'b01);
    chk("rd_rsp_done", {done1, done0}, 2'b01);
    chk("rd_rsp_strb", {ram_ena, ram_read, ram_write}, 3'b000);
    chk("rd_rsp_data", rdata, 8'hA5);
    req0 = 0;
    tick(1);
    chk("rd_idle_gnt",  {gnt1, gnt0}, 2'b00);
    chk("rd_idle_done", {done1, done0}, 2'b00);
    chk("rd_idle_hold", rdata, 8'hA5);

    // Single write, port 1, 0x3C to 0x20
    req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
    tick(1);
    chk("wr_acc_gnt",   {gnt1, gnt0}, 2'b10);
    chk("wr_acc_strb",  {ram_ena, ram_read, ram_write}, 3'b101);
    chk("wr_acc_addr",  ram_addr, 8'h20);
    chk("wr_acc_wdata", ram_wdata, 8'h3C);
    tick(1);
    chk("wr_rsp_strb", {ram_ena, ram_read, ram_write}, 3'b000);
    chk("wr_rsp_done", {done1, done0}, 2'b10);
    chk("wr_rsp_rdata", rdata, 8'hA5);
    req1 = 0; we1 = 0;
    tick(1);
    // Read back 0x20 on port 0
    req0 = 1; we0 = 0; addr0 = 8'h20;
    tick(2);
    chk("rb_done", done0, 1'b1);
    chk("rb_data", rdata, 8'h3C);
    req0 = 0;
    tick(1);

    // Tie after reset: both held, order 0,1,0,1 three cycles apart
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    req0 = 1; we0 = 0; addr0 = 8'h10;
    req1 = 1; we1 = 0; addr1 = 8'h20;
    tick(1);
    chk("tie1_gnt", {gnt1, gnt0}, 2'b01);
    tick(1);
    chk("tie1_data", rdata, 8'hA5);
    tick(2);
    chk("tie2_gnt", {gnt1, gnt0}, 2'b10);
    tick(1);
    chk("tie2_data", rdata, 8'h3C);
    tick(2);
    chk("tie3_gnt", {gnt1, gnt0}, 2'b01);
    tick(3);
    chk("tie4_gnt", {gnt1, gnt0}, 2'b10);
    tick(1);
    chk("tie4_done", {done1, done0}, 2'b10);
    req0 = 0; req1 = 0;
    tick(1);
    chk("tie_idle", {gnt1, gnt0}, 2'b00);

    // Lock: port 1 reads 0x30 locked while port 0 waits
    req1 = 1; we1 = 0; addr1 = 8'h30; lock1 = 1;
    tick(1);
    chk("lk_gnt1", {gnt1, gnt0}, 2'b10);
    req0 = 1; we0 = 0; addr0 = 8'h10;
    tick(1);
    chk("lk_rdata", rdata, 8'h5A);
    req1 = 0;
    tick(2);
    chk("lk_ignore0", {gnt1, gnt0}, 2'b00);
    req1 = 1; we1 = 1; addr1 = 8'h30; wdata1 = 8'h77; lock1 = 0;
    tick(1);
    chk("lk_wr_gnt",  {gnt1, gnt0}, 2'b10);
    chk("lk_wr_strb", {ram_write, ram_addr, ram_wdata}, {1'b1, 8'h30, 8'h77});
    tick(1);
    req1 = 0; we1 = 0;
    tick(2);
    chk("lk_rel_gnt0", {gnt1, gnt0}, 2'b01);
    tick(1);
    chk("lk_rel_data", rdata, 8'hA5);
    chk("lk_mem30", mem[8'h30], 8'h77);
    req0 = 0;
    tick(1);

    // req0 dropped during ACC still completes
    req0 = 1; we0 = 0; addr0 = 8'h20;
    tick(1);
    chk("drop_acc_gnt", gnt0, 1'b1);
    req0 = 0;
    tick(1);
    chk("drop_done", done0, 1'b1);
    chk("drop_data", rdata, 8'h3C);
    tick(2);
    chk("drop_nogrant", {gnt1, gnt0, ram_ena}, 3'b000);

    // Reset mid-ACC during a write
    req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h99;
    tick(1);
    chk("mr_acc_write", ram_write, 1'b1);
    rst = 1'b0;
    #1;
    chk("mr_strb",  {ram_ena, ram_read, ram_write}, 3'b000);
    chk("mr_gnt",   {gnt1, gnt0, done1, done0}, 4'b0000);
    chk("mr_regs",  {rdata, ram_addr, ram_wdata}, 24'h000000);
    req0 = 0; we0 = 0;
    tick(1);
    chk("mr_nodone", {done1, done0}, 2'b00);
    chk("mr_mem40", mem[8'h40], 8'h00);
    rst = 1'b1;
    req0 = 1; we0 = 0; addr0 = 8'h10;
    tick(1);
    chk("mr_post_gnt", {gnt1, gnt0}, 2'b01);
    tick(1);
    chk("mr_post_done", done0, 1'b1);
    chk("mr_post_data", rdata, 8'hA5);
    req0 = 0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
